md5_result_check: RTL and testbench
===================================

Name: md5_result_check

Overview:
- Downstream consumer of the 64-stage hash_op pipeline.
- Takes the final a/b/c/d of the last stage plus the 19-char candidate message and adds the MD5 initial values to form the digest.
- Compares the digest against a 128-bit target loaded byte-serially, and latches the first matching message for the host interface, with a match/ack handshake and a checked-hash counter.

Parameters:
- IV_A, 32'h67452301, MD5 initial value A added to a_in
- IV_B, 32'hefcdab89, initial value B
- IV_C, 32'h98badcfe, initial value C
- IV_D, 32'h10325476, initial value D
- MSG_BITS, 152, candidate message width (19 chars)

Ports:
- clk_12mhz  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  pipeline enable; when low, pipeline registers hold and valid_in is ignored
- load_start  in  1  pulse: clear target index, enter LOAD state
- target_wr  in  1  strobe, target_byte valid this cycle
- target_byte  in  8  digest byte, printed (hex-string) order
- a_in, b_in, c_in, d_in  in  32 each  final state from last hash_op stage
- m_in  in  MSG_BITS  message aligned with a_in..d_in
- valid_in  in  1  a_in..m_in valid this cycle
- armed  out  1  target fully loaded, comparing
- match  out  1  first match captured, held until acked
- match_msg  out  MSG_BITS  message that matched
- match_ack  in  1  host acknowledge, releases match
- multi_match  out  1  sticky: a further match arrived while match was held
- hash_count  out  32  digests compared while armed (wraps at 2^32)

Behaviour:
- Reset values:
  - outputs: armed=0, match=0, match_msg=0, multi_match=0, hash_count=0.
  - internal: target=0, byte index=0, state=LOAD, pipeline valids=0.
- Target byte mapping (MD5 digest is little-endian per word):
  - byte k of 0..15 maps to word w=k/4 (0=a, 1=b, 2=c, 3=d), bits [8*(k%4)+7 : 8*(k%4)].
- State LOAD:
  - armed=0; each target_wr writes byte at index, index++.
  - On the write of byte 15: go ARMED, index->0.
  - target_wr when not in LOAD is ignored.
- State ARMED:
  - armed=1.
  - A registered hit with armed: match<=1, match_msg<=message, go MATCHED.
- State MATCHED:
  - match=1 held.
  - A further hit sets multi_match.
  - match_ack: match<=0, go ARMED (multi_match stays until load_start or reset).
- load_start, any state: go LOAD, index=0, match=0, multi_match=0, hash_count=0.
  - match_msg and the target registers keep their old contents until overwritten.
  - load_start wins over a simultaneous match_ack or hit.
- Pipeline, when en=1:
  - Stage 1 registers sum_a=a_in+IV_A, sum_b, sum_c, sum_d (each mod 2^32), plus the message and the valid.
  - Stage 2 registers hit = valid1 & ({sum_a,sum_b,sum_c,sum_d} == target), plus message and valid2.
  - The FSM acts on the stage-2 outputs.
- Latency:
  - valid_in sampled at edge N gives match high after edge N+2 (2 cycles), provided the state was ARMED.
- hash_count increments on each valid2 while in ARMED or MATCHED.
- Hits that reach stage 2 while in LOAD are discarded and not counted.
- Simultaneous hit and match_ack in MATCHED:
  - ack is honoured and the new hit is not captured (state->ARMED, match=0).
  - The hit sets multi_match.
  - This guarantees no silent overwrite of match_msg.
- Reset mid-operation clears everything including the target; a full re-load is required.
- Back-to-back valid_in every cycle is supported (throughput 1 per clock).

Test Plan:
- Load bytes 01 23 45 67 89 ab cd ef fe dc ba 98 76 54 32 10, drive a..d_in=0, m_in="The quick brown fox", one valid_in pulse.
  - armed=1 after the 16th byte.
  - match=1 exactly 2 cycles after valid_in.
  - match_msg=152'h54686520_71756963_6b206272_6f776e20_666f78.
  - hash_count=1.
- Integration: target a2004f37730b9445670a738fa0fc9ee5, feed the fox message through the 64 hash_op stages.
  - match asserted, match_msg equals the fox message.
- Same target, a_in=1 with others 0.
  - No match, hash_count=1, multi_match=0.
- Load zero target (byte values 01,23..10 as above), send 3 matching valids back-to-back.
  - match_msg is the first message.
  - multi_match=1, hash_count=3.
- Pulse match_ack in the same cycle as a second hit.
  - match=0, state ARMED, multi_match=1.
  - A third matching valid re-asserts match 2 cycles later.
- Only 15 bytes loaded, then a matching valid.
  - armed=0, no match, hash_count=0.
- Then assert load_start mid-operation and reload 16 bytes.
  - Index restarts at 0, armed only after the 16th byte.

Source files
------------

// File: rtl/md5_result_check.sv
// rtl/md5_result_check.sv - MD5 digest finalisation, target compare and first-match capture
//
// Adds the MD5 initial values to the last hash_op stage outputs, compares the
// digest with a byte-serially loaded 128-bit target, and holds the first
// matching message for the host until acknowledged.
//
// Ports:
//   clk_12mhz             system clock, rising edge
//   reset                 synchronous, active-high
//   en                    pipeline enable (stages hold when low)
//   load_start            restart target loading
//   target_wr/target_byte digest byte strobe, printed hex-string order
//   a_in..d_in, m_in      final hash state and candidate message
//   valid_in              a_in..m_in valid
//   armed                 target loaded, comparing
//   match/match_msg       first captured match, held until match_ack
//   match_ack             host release of match
//   multi_match           sticky: another hit arrived while match was held
//   hash_count            digests compared while armed
module md5_result_check #(
  parameter logic [31:0] IV_A     = 32'h67452301,
  parameter logic [31:0] IV_B     = 32'hefcdab89,
  parameter logic [31:0] IV_C     = 32'h98badcfe,
  parameter logic [31:0] IV_D     = 32'h10325476,
  parameter int          MSG_BITS = 152
) (
  input  logic                clk_12mhz,
  input  logic                reset,
  input  logic                en,
  input  logic                load_start,
  input  logic                target_wr,
  input  logic [7:0]          target_byte,
  input  logic [31:0]         a_in,
  input  logic [31:0]         b_in,
  input  logic [31:0]         c_in,
  input  logic [31:0]         d_in,
  input  logic [MSG_BITS-1:0] m_in,
  input  logic                valid_in,
  output logic                armed,
  output logic                match,
  output logic [MSG_BITS-1:0] match_msg,
  input  logic                match_ack,
  output logic                multi_match,
  output logic [31:0]         hash_count
);

  typedef enum logic [1:0] {ST_LOAD, ST_ARMED, ST_MATCHED} state_t;

  state_t              state;
  logic [7:0]          tgt [16];
  logic [3:0]          idx;
  logic [127:0]        target;

  logic [31:0]         sum_a, sum_b, sum_c, sum_d;
  logic [MSG_BITS-1:0] msg1, msg2;
  logic                valid1, valid2, hit2;
  logic                ev_valid, ev_hit;

  // Each digest word is little-endian: the first printed byte of a word is
  // its least significant byte.
  assign target = {tgt[3],  tgt[2],  tgt[1],  tgt[0],
                   tgt[7],  tgt[6],  tgt[5],  tgt[4],
                   tgt[11], tgt[10], tgt[9],  tgt[8],
                   tgt[15], tgt[14], tgt[13], tgt[12]};

  // Stage 2 only hands a result to the FSM on an enabled edge, so a result
  // held while en is low is consumed exactly once.
  assign ev_valid = en & valid2;
  assign ev_hit   = en & hit2;

  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      sum_a  <= '0;
      sum_b  <= '0;
      sum_c  <= '0;
      sum_d  <= '0;
      msg1   <= '0;
      msg2   <= '0;
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      hit2   <= 1'b0;
    end else if (en) begin
      sum_a  <= a_in + IV_A;
      sum_b  <= b_in + IV_B;
      sum_c  <= c_in + IV_C;
      sum_d  <= d_in + IV_D;
      msg1   <= m_in;
      valid1 <= valid_in;
      hit2   <= valid1 && ({sum_a, sum_b, sum_c, sum_d} == target);
      msg2   <= msg1;
      valid2 <= valid1;
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      state       <= ST_LOAD;
      idx         <= '0;
      armed       <= 1'b0;
      match       <= 1'b0;
      match_msg   <= '0;
      multi_match <= 1'b0;
      hash_count  <= '0;
      for (int i = 0; i < 16; i++) tgt[i] <= '0;
    end else if (load_start) begin
      state       <= ST_LOAD;
      idx         <= '0;
      armed       <= 1'b0;
      match       <= 1'b0;
      multi_match <= 1'b0;
      hash_count  <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (target_wr) begin
            tgt[idx] <= target_byte;
            if (idx == 4'd15) begin
              idx   <= '0;
              state <= ST_ARMED;
              armed <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_ARMED: begin
          if (ev_valid) hash_count <= hash_count + 32'd1;
          if (ev_hit) begin
            match     <= 1'b1;
            match_msg <= msg2;
            state     <= ST_MATCHED;
          end
        end
        ST_MATCHED: begin
          if (ev_valid) hash_count <= hash_count + 32'd1;
          // A hit here is never captured, even alongside an ack, so the
          // held message cannot be silently replaced.
          if (ev_hit) multi_match <= 1'b1;
          if (match_ack) begin
            match <= 1'b0;
            state <= ST_ARMED;
          end
        end
        default: begin
          state <= ST_LOAD;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_result_check.sv
// tb/tb_md5_result_check.sv - scoreboard bench for md5_result_check
module tb_md5_result_check;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [151:0] FOX  = 152'h54686520_71756963_6b206272_6f776e20_666f78;
  localparam logic [127:0] T_IV = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] T_FOX = 128'ha2004f37730b9445670a738fa0fc9ee5;

  logic         clk_12mhz = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b1;
  logic         load_start = 1'b0;
  logic         target_wr = 1'b0;
  logic [7:0]   target_byte = '0;
  logic [31:0]  a_in = '0, b_in = '0, c_in = '0, d_in = '0;
  logic [151:0] m_in = '0;
  logic         valid_in = 1'b0;
  logic         match_ack = 1'b0;
  logic         armed, match, multi_match;
  logic [151:0] match_msg;
  logic [31:0]  hash_count;

  md5_result_check dut (
    .clk_12mhz   (clk_12mhz),
    .reset       (reset),
    .en          (en),
    .load_start  (load_start),
    .target_wr   (target_wr),
    .target_byte (target_byte),
    .a_in        (a_in),
    .b_in        (b_in),
    .c_in        (c_in),
    .d_in        (d_in),
    .m_in        (m_in),
    .valid_in    (valid_in),
    .armed       (armed),
    .match       (match),
    .match_msg   (match_msg),
    .match_ack   (match_ack),
    .multi_match (multi_match),
    .hash_count  (hash_count)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int n_cmp = 0;
  int n_err = 0;
  logic [151:0] exp_q [$];
  logic [7:0]   tb_bytes [16];
  logic         match_seen = 1'b0;
  logic [31:0]  wa, wb, wc, wd;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic set_target(input logic [127:0] hexstr);
    for (int k = 0; k < 16; k++) tb_bytes[k] = hexstr[127-8*k -: 8];
    wa = {tb_bytes[3],  tb_bytes[2],  tb_bytes[1],  tb_bytes[0]};
    wb = {tb_bytes[7],  tb_bytes[6],  tb_bytes[5],  tb_bytes[4]};
    wc = {tb_bytes[11], tb_bytes[10], tb_bytes[9],  tb_bytes[8]};
    wd = {tb_bytes[15], tb_bytes[14], tb_bytes[13], tb_bytes[12]};
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic load_bytes(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      target_wr   = 1'b1;
      target_byte = tb_bytes[k];
      tick();
    end
    target_wr = 1'b0;
  endtask

  // Drives final-stage values that make the digest equal the current target.
  task automatic send_match(input logic [151:0] msg, input bit expect_capture);
    a_in = wa - IV_A;
    b_in = wb - IV_B;
    c_in = wc - IV_C;
    d_in = wd - IV_D;
    m_in = msg;
    valid_in = 1'b1;
    if (expect_capture) exp_q.push_back(msg);
    tick();
    valid_in = 1'b0;
  endtask

  always @(negedge clk_12mhz) begin
    if (match && !match_seen) begin
      if (exp_q.size() == 0) check("unexpected_match", 160'(match), 160'd0);
      else check("match_msg", 160'(match_msg), 160'(exp_q.pop_front()));
    end
    match_seen = match;
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_armed", 160'(armed), 160'd0);
    check("rst_match", 160'(match), 160'd0);
    check("rst_msg", 160'(match_msg), 160'd0);
    check("rst_multi", 160'(multi_match), 160'd0);
    check("rst_count", 160'(hash_count), 160'd0);

    // Basic: IV target, zero state, fox message, exact latency
    set_target(T_IV);
    load_bytes(0, 15);
    check("armed_after15", 160'(armed), 160'd0);
    load_bytes(15, 1);
    check("armed_after16", 160'(armed), 160'd1);
    a_in = '0; b_in = '0; c_in = '0; d_in = '0; m_in = FOX;
    valid_in = 1'b1;
    exp_q.push_back(FOX);
    tick();
    valid_in = 1'b0;
    check("lat_n0", 160'(match), 160'd0);
    tick();
    check("lat_n1", 160'(match), 160'd0);
    tick();
    check("lat_n2", 160'(match), 160'd1);
    check("basic_count", 160'(hash_count), 160'd1);
    match_ack = 1'b1;
    tick();
    match_ack = 1'b0;
    check("ack_release", 160'(match), 160'd0);

    // Real MD5 of the fox message as target
    pulse_load_start();
    set_target(T_FOX);
    load_bytes(0, 16);
    send_match(FOX, 1'b1);
    repeat (3) tick();
    check("fox_match", 160'(match), 160'd1);
    check("fox_count", 160'(hash_count), 160'd1);

    // Same target, wrong state
    pulse_load_start();
    load_bytes(0, 16);
    a_in = 32'd1; b_in = '0; c_in = '0; d_in = '0; m_in = FOX;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (3) tick();
    check("nomatch_match", 160'(match), 160'd0);
    check("nomatch_count", 160'(hash_count), 160'd1);
    check("nomatch_multi", 160'(multi_match), 160'd0);

    // Three back-to-back hits: first captured, rest flag multi_match
    pulse_load_start();
    set_target(T_IV);
    load_bytes(0, 16);
    send_match(152'h111, 1'b1);
    send_match(152'h222, 1'b0);
    send_match(152'h333, 1'b0);
    repeat (3) tick();
    check("b2b_match", 160'(match), 160'd1);
    check("b2b_msg_kept", 160'(match_msg), 160'h111);
    check("b2b_multi", 160'(multi_match), 160'd1);
    check("b2b_count", 160'(hash_count), 160'd3);

    // Ack coinciding with a second hit
    pulse_load_start();
    check("ls_clears_multi", 160'(multi_match), 160'd0);
    load_bytes(0, 16);
    send_match(152'h444, 1'b1);
    repeat (3) tick();
    check("pre_ack_match", 160'(match), 160'd1);
    send_match(152'h555, 1'b0);
    tick();
    match_ack = 1'b1;
    tick();
    match_ack = 1'b0;
    check("ackhit_match", 160'(match), 160'd0);
    check("ackhit_armed", 160'(armed), 160'd1);
    check("ackhit_multi", 160'(multi_match), 160'd1);
    check("ackhit_msg", 160'(match_msg), 160'h444);
    send_match(152'h666, 1'b1);
    tick();
    check("third_n1", 160'(match), 160'd0);
    tick();
    check("third_n2", 160'(match), 160'd1);
    check("third_count", 160'(hash_count), 160'd3);

    // Incomplete load never arms
    pulse_load_start();
    load_bytes(0, 15);
    send_match(152'h777, 1'b0);
    repeat (3) tick();
    check("partial_armed", 160'(armed), 160'd0);
    check("partial_match", 160'(match), 160'd0);
    check("partial_count", 160'(hash_count), 160'd0);

    // Reload restarts index at 0
    pulse_load_start();
    load_bytes(0, 15);
    check("reload_armed15", 160'(armed), 160'd0);
    load_bytes(15, 1);
    check("reload_armed16", 160'(armed), 160'd1);
    // Writes while armed are ignored
    target_wr = 1'b1;
    target_byte = 8'hff;
    tick();
    target_wr = 1'b0;
    send_match(152'h888, 1'b1);
    repeat (3) tick();
    check("wr_ignored_match", 160'(match), 160'd1);

    // Reset mid-operation clears everything
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send_match(152'h999, 1'b0);
    repeat (3) tick();
    check("midrst_armed", 160'(armed), 160'd0);
    check("midrst_match", 160'(match), 160'd0);
    check("midrst_msg", 160'(match_msg), 160'd0);
    check("midrst_count", 160'(hash_count), 160'd0);

    check("sb_drain", 160'(exp_q.size()), 160'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
